// File: rtl/swa_pkg.sv
// Shared definitions for the serial wide adder: slice width, FSM states and
// the slice-count helper used to size the operand walk.
package swa_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } swa_state_e;

    // Number of 16-bit slices needed to cover a width (width is a multiple of 16).
    function automatic int unsigned slice_count(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/serial_wide_adder_if.sv
// Operand/result handshake bundle for serial_wide_adder.
// Optional macro SWA_OVF_EN adds the out_ovf signal.
interface serial_wide_adder_if #(
    parameter int unsigned WIDTH = 64
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef SWA_OVF_EN
    logic             out_ovf;
`endif

    // Producer/consumer side.
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
`ifdef SWA_OVF_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_sum, out_cout
    );

    // Adder side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
`ifdef SWA_OVF_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/rca_slice16.sv
// 16-bit ripple-carry adder slice, purely combinational.
module rca_slice16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] w_carry;

    // Explicit ripple chain: one full adder per bit.
    always_comb begin
        w_carry[0] = cin;
        for (int i = 0; i < 16; i++) begin
            sum[i]         = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
        cout = w_carry[16];
    end

endmodule

// File: rtl/serial_wide_adder.sv
// Multi-cycle WIDTH-bit adder: walks the operands one 16-bit slice per cycle,
// LSB first, through a single rca_slice16 with a registered carry.
// Optional macro SWA_OVF_EN adds the registered signed-overflow output.
module serial_wide_adder
    import swa_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    serial_wide_adder_if.slave  bus
);

    localparam int unsigned N     = slice_count(WIDTH);
    localparam int unsigned IDX_W = $clog2(N);

    swa_state_e       r_state;
    swa_state_e       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SWA_OVF_EN
    logic             r_ovf;
    logic             w_ovf;
`endif

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_last;
    logic [15:0]      w_a_slice;
    logic [15:0]      w_b_slice;
    logic [15:0]      w_slice_sum;
    logic             w_slice_cout;

    assign w_last    = (r_idx == IDX_W'(N - 1));
    assign w_a_slice = r_a[r_idx * SLICE_W +: SLICE_W];
    assign w_b_slice = r_b[r_idx * SLICE_W +: SLICE_W];

    rca_slice16 u_slice (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

`ifdef SWA_OVF_EN
    // Sign of the final sum comes straight from the last slice's MSB.
    assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                   (w_slice_sum[SLICE_W-1] != r_a[WIDTH-1]);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore handshake outputs; in_ready is also masked by rst.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = !rst;
                if (bus.in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, per-slice write-back and final carry/overflow capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SWA_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                        r_carry <= bus.in_cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx * SLICE_W +: SLICE_W] <= w_slice_sum;
                    r_carry <= w_slice_cout;
                    // Index parks at N-1 on exit instead of wrapping.
                    if (w_last) begin
                        r_cout <= w_slice_cout;
`ifdef SWA_OVF_EN
                        r_ovf  <= w_ovf;
`endif
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
`ifdef SWA_OVF_EN
    assign bus.out_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_wide_adder.sv
// Directed self-checking bench for serial_wide_adder at WIDTH=64.
// Checks out_ovf only when built with SWA_OVF_EN.
module tb_serial_wide_adder;

    localparam int unsigned W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    // Back-to-back vectors with hand-computed results.
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic        vc [4];
    logic [63:0] es [4];
    logic        ec [4];
    logic        eo [4];

    serial_wide_adder_if #(.WIDTH(W)) bus ();

    serial_wide_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string name, input logic [63:0] exp_sum,
                                input logic exp_cout, input logic exp_ovf);
        tests++;
        if (bus.out_sum !== exp_sum) begin
            fails++;
            $display("FAIL %s sum: got %h required %h", name, bus.out_sum, exp_sum);
        end
        tests++;
        if (bus.out_cout !== exp_cout) begin
            fails++;
            $display("FAIL %s cout: got %b required %b", name, bus.out_cout, exp_cout);
        end
`ifdef SWA_OVF_EN
        tests++;
        if (bus.out_ovf !== exp_ovf) begin
            fails++;
            $display("FAIL %s ovf: got %b required %b", name, bus.out_ovf, exp_ovf);
        end
`else
        if (exp_ovf === 1'bz) $display("note: ovf expectation undriven in %s", name);
`endif
    endtask

    // One full operation: accept, count latency, check result, release.
    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic [63:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf);
        int guard;
        int lat;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: in_ready=%b required 1", name, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        tests++;
        if (lat != 4) begin
            fails++;
            $display("FAIL %s latency: got %0d required 4", name, lat);
        end
        check_result(name, exp_sum, exp_cout, exp_ovf);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", name,
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 0/0", bus.in_ready,
                     bus.out_valid);
        end
        check_result("reset", 64'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_carry_ripple;
        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow;
        run_op("overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000,
               1'b0, 1'b1);
    endtask

    task automatic test_cin_carry;
        run_op("cin", 64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0001_0000_0000_0000,
               1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        int guard;
        bus.in_a      = 64'h1234_5678_9ABC_DEF0;
        bus.in_b      = 64'h1111_1111_1111_1111;
        bus.in_cin    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_valid: out_valid=%b required 1", bus.out_valid);
        end
        // A different operand on the bus must not be captured while held.
        bus.in_a = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_sum !== 64'h2345_6789_ABCD_F001 || bus.out_cout !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b sum=%h cout=%b", i,
                         bus.out_valid, bus.in_ready, bus.out_sum, bus.out_cout);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready,
                     bus.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int acc_n;
        int res_n;
        int cyc;
        int last_acc;
        va[0] = 64'h0000_0000_0000_0001; vb[0] = 64'h0000_0000_0000_0002; vc[0] = 1'b0;
        es[0] = 64'h0000_0000_0000_0003; ec[0] = 1'b0; eo[0] = 1'b0;
        va[1] = 64'hFFFF_0000_FFFF_0000; vb[1] = 64'h0001_0000_0001_0000; vc[1] = 1'b0;
        es[1] = 64'h0000_0001_0000_0000; ec[1] = 1'b1; eo[1] = 1'b0;
        va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000; vc[2] = 1'b1;
        es[2] = 64'h0000_0000_0000_0001; ec[2] = 1'b1; eo[2] = 1'b1;
        va[3] = 64'h1234_5678_9ABC_DEF0; vb[3] = 64'h1111_1111_1111_1111; vc[3] = 1'b0;
        es[3] = 64'h2345_6789_ABCD_F001; ec[3] = 1'b0; eo[3] = 1'b0;
        acc_n    = 0;
        res_n    = 0;
        cyc      = 0;
        last_acc = 0;
        bus.out_ready = 1'b1;
        bus.in_a      = va[0];
        bus.in_b      = vb[0];
        bus.in_cin    = vc[0];
        bus.in_valid  = 1'b1;
        while (res_n < 4 && cyc < 60) begin
            if (bus.out_valid === 1'b1) begin
                check_result($sformatf("b2b%0d", res_n), es[res_n], ec[res_n], eo[res_n]);
                res_n++;
            end
            if (bus.in_ready === 1'b1 && acc_n < 4) begin
                if (acc_n > 0) begin
                    tests++;
                    if (cyc - last_acc != 6) begin
                        fails++;
                        $display("FAIL b2b_interval %0d: got %0d required 6", acc_n,
                                 cyc - last_acc);
                    end
                end
                last_acc = cyc;
                acc_n++;
                tick();
                cyc++;
                if (acc_n < 4) begin
                    bus.in_a   = va[acc_n];
                    bus.in_b   = vb[acc_n];
                    bus.in_cin = vc[acc_n];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end else begin
                tick();
                cyc++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tests++;
        if (res_n != 4) begin
            fails++;
            $display("FAIL b2b_count: got %0d results required 4", res_n);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        bus.in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.in_b     = 64'h1;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        tick();               // acceptance edge; idx=0
        bus.in_valid = 1'b0;
        tick();               // idx=1
        if (bus.out_valid === 1'b1) seen++;
        tick();               // idx=2
        if (bus.out_valid === 1'b1) seen++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_ready: in_ready=%b required 1", bus.in_ready);
        end
        check_result("rstmid", 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid === 1'b1) seen++;
            tick();
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rstmid_valid: out_valid seen %0d times required 0", seen);
        end
        run_op("after_rst", 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0,
               64'h0000_0000_0000_0003, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_carry_ripple();
        test_overflow();
        test_cin_carry();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
